// File: rtl/branch_target_predictor.sv
// Branch predictor: per-entry saturating counters plus a tagged target buffer.
// Lookup is combinational from the fetch PC. Training happens on the clock edge
// from the ID-stage resolution. MODE selects bimodal (0) or gshare (1) indexing.
module branch_target_predictor #(
  parameter int ENTRIES = 64,
  parameter int INDEX_W = $clog2(ENTRIES),
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int GHR_W   = 6,
  parameter int MODE    = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      lu_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic [GHR_W-1:0] upd_ghr,
  input  logic             upd_is_branch,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_mispredict,
  output logic [31:0]      stat_lookups,
  output logic [31:0]      stat_mispredicts
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  logic [ENTRIES-1:0]            r_valid;
  logic [ENTRIES-1:0][TAG_W-1:0] r_tag;
  logic [ENTRIES-1:0][29:0]      r_tgt;
  logic [ENTRIES-1:0][CNT_W-1:0] r_cnt;
  logic [GHR_W-1:0]              r_ghr;
  logic [31:0]                   r_stat_lk;
  logic [31:0]                   r_stat_mp;

  logic [INDEX_W-1:0] w_lu_idx, w_upd_idx;
  logic [TAG_W-1:0]   w_lu_tag, w_upd_tag;
  logic               w_lu_hit, w_upd_hit;
  logic [GHR_W:0]     w_ghr_shift;
  logic               w_unused;

  // Index/tag extraction; gshare folds history into the low index bits.
  always_comb begin
    w_lu_idx  = lu_pc[INDEX_W+1:2];
    w_upd_idx = upd_pc[INDEX_W+1:2];
    if (MODE == 1) begin
      w_lu_idx  = w_lu_idx  ^ INDEX_W'(r_ghr);
      w_upd_idx = w_upd_idx ^ INDEX_W'(upd_ghr);
    end
    w_lu_tag  = lu_pc[TAG_W+INDEX_W+1:INDEX_W+2];
    w_upd_tag = upd_pc[TAG_W+INDEX_W+1:INDEX_W+2];
  end

  assign w_lu_hit    = r_valid[w_lu_idx]  && (r_tag[w_lu_idx]  == w_lu_tag);
  assign w_upd_hit   = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_ghr_shift = {r_ghr, upd_taken};
  assign w_unused    = ^{lu_pc, upd_pc, upd_target[1:0]};

  assign pred_hit         = w_lu_hit;
  assign pred_taken       = w_lu_hit && r_cnt[w_lu_idx][CNT_W-1];
  assign pred_target      = pred_taken ? {r_tgt[w_lu_idx], 2'b00} : lu_pc + 32'd4;
  assign pred_ghr         = r_ghr;
  assign stat_lookups     = r_stat_lk;
  assign stat_mispredicts = r_stat_mp;

  // Table training: jumps and taken misses allocate, branch hits adjust the counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_tgt[i]   <= '0;
        r_cnt[i]   <= CNT_WEAK;
      end
    end else if (upd_valid) begin
      if (!upd_is_branch || (!w_upd_hit && upd_taken)) begin
        r_valid[w_upd_idx] <= 1'b1;
        r_tag[w_upd_idx]   <= w_upd_tag;
        r_tgt[w_upd_idx]   <= upd_target[31:2];
        r_cnt[w_upd_idx]   <= CNT_MAX;
      end else if (w_upd_hit) begin
        if (upd_taken) begin
          r_tgt[w_upd_idx] <= upd_target[31:2];
          if (r_cnt[w_upd_idx] != CNT_MAX)
            r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] + CNT_W'(1);
        end else if (r_cnt[w_upd_idx] != '0) begin
          r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] - CNT_W'(1);
        end
      end
    end
  end

  // Global history shifts only on conditional branch outcomes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                        r_ghr <= '0;
    else if (upd_valid && upd_is_branch) r_ghr <= w_ghr_shift[GHR_W-1:0];
  end

  // Saturating resolution / mispredict counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stat_lk <= '0;
      r_stat_mp <= '0;
    end else if (upd_valid) begin
      if (r_stat_lk != '1) r_stat_lk <= r_stat_lk + 32'd1;
      if (upd_mispredict && (r_stat_mp != '1)) r_stat_mp <= r_stat_mp + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench: bimodal instance (u_dut) and a gshare instance (u_gs, GHR_W=2).
module tb_branch_target_predictor;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  // bimodal instance signals
  logic [31:0] lu_pc = '0;
  logic        hit, tkn;
  logic [31:0] tgt;
  logic [5:0]  ghr;
  logic        uv = 1'b0, ub = 1'b0, ut = 1'b0, um = 1'b0;
  logic [31:0] upc = '0, utgt = '0;
  logic [5:0]  ughr = '0;
  logic [31:0] s_lk, s_mp;
  // gshare instance signals
  logic [31:0] g_lu_pc = '0;
  logic        g_hit, g_tkn;
  logic [31:0] g_tgt;
  logic [1:0]  g_ghr;
  logic        g_uv = 1'b0, g_ub = 1'b0, g_ut = 1'b0;
  logic [31:0] g_upc = '0, g_utgt = '0;
  logic [1:0]  g_ughr = '0;
  logic [31:0] g_s_lk, g_s_mp;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  branch_target_predictor #(.ENTRIES(64), .TAG_W(8), .CNT_W(2), .GHR_W(6), .MODE(0)) u_dut (
    .clock(clock), .reset(reset), .lu_pc(lu_pc),
    .pred_hit(hit), .pred_taken(tkn), .pred_target(tgt), .pred_ghr(ghr),
    .upd_valid(uv), .upd_pc(upc), .upd_ghr(ughr), .upd_is_branch(ub),
    .upd_taken(ut), .upd_target(utgt), .upd_mispredict(um),
    .stat_lookups(s_lk), .stat_mispredicts(s_mp));

  branch_target_predictor #(.ENTRIES(64), .TAG_W(8), .CNT_W(2), .GHR_W(2), .MODE(1)) u_gs (
    .clock(clock), .reset(reset), .lu_pc(g_lu_pc),
    .pred_hit(g_hit), .pred_taken(g_tkn), .pred_target(g_tgt), .pred_ghr(g_ghr),
    .upd_valid(g_uv), .upd_pc(g_upc), .upd_ghr(g_ughr), .upd_is_branch(g_ub),
    .upd_taken(g_ut), .upd_target(g_utgt), .upd_mispredict(1'b0),
    .stat_lookups(g_s_lk), .stat_mispredicts(g_s_mp));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // one training edge on the bimodal instance
  task automatic upd(input logic [31:0] pc, input logic br, input logic t,
                     input logic [31:0] target, input logic mp);
    @(negedge clock);
    uv = 1'b1; upc = pc; ub = br; ut = t; utgt = target; um = mp;
    @(posedge clock); #1;
    uv = 1'b0; um = 1'b0;
  endtask

  // one training edge on the gshare instance
  task automatic gupd(input logic [31:0] pc, input logic [1:0] h, input logic br,
                      input logic t, input logic [31:0] target);
    @(negedge clock);
    g_uv = 1'b1; g_upc = pc; g_ughr = h; g_ub = br; g_ut = t; g_utgt = target;
    @(posedge clock); #1;
    g_uv = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc, input string tag, input logic eh,
                      input logic et, input logic [31:0] etgt);
    lu_pc = pc; #1;
    chk({tag, ".hit"}, 32'(hit), 32'(eh));
    chk({tag, ".taken"}, 32'(tkn), 32'(et));
    chk({tag, ".target"}, tgt, etgt);
  endtask

  initial begin
    // reset state
    lu_pc = 32'h40;
    #12;
    look(32'h40, "rst", 1'b0, 1'b0, 32'h44);
    chk("rst.ghr", 32'(ghr), 32'h0);
    chk("rst.lookups", s_lk, 32'h0);
    chk("rst.mispred", s_mp, 32'h0);
    @(negedge clock); reset = 1'b1;

    // allocate on taken miss, cnt = 11
    upd(32'h40, 1'b1, 1'b1, 32'h100, 1'b0);
    look(32'h40, "alloc", 1'b1, 1'b1, 32'h100);
    chk("alloc.lookups", s_lk, 32'd1);

    // saturation down: 11->10->01->00->00
    upd(32'h40, 1'b1, 1'b0, 32'h0, 1'b0);
    look(32'h40, "nt1", 1'b1, 1'b1, 32'h100);
    upd(32'h40, 1'b1, 1'b0, 32'h0, 1'b0);
    look(32'h40, "nt2", 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 1'b0, 32'h0, 1'b0);
    upd(32'h40, 1'b1, 1'b0, 32'h0, 1'b0);
    look(32'h40, "nt4", 1'b1, 1'b0, 32'h44);
    // 00 -> 01 still not taken, then 10 taken with new target
    upd(32'h40, 1'b1, 1'b1, 32'h180, 1'b0);
    look(32'h40, "t01", 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 1'b1, 32'h180, 1'b0);
    look(32'h40, "t10", 1'b1, 1'b1, 32'h180);
    chk("sat.lookups", s_lk, 32'd7);

    // alias: 0x140 shares index 16 with 0x40, different tag
    upd(32'h140, 1'b1, 1'b1, 32'h200, 1'b0);
    look(32'h40, "alias40", 1'b0, 1'b0, 32'h44);
    look(32'h140, "alias140", 1'b1, 1'b1, 32'h200);

    // not-taken miss does not allocate
    upd(32'h80, 1'b1, 1'b0, 32'h900, 1'b0);
    look(32'h80, "ntmiss", 1'b0, 1'b0, 32'h84);

    // jump allocates with cnt max
    upd(32'hC0, 1'b0, 1'b1, 32'h300, 1'b0);
    look(32'hC0, "jump", 1'b1, 1'b1, 32'h300);

    // fall-through wraps modulo 2^32
    look(32'hFFFF_FFFC, "wrap", 1'b0, 1'b0, 32'h0);

    // same-cycle lookup and update to same entry: old value until the edge
    @(negedge clock);
    lu_pc = 32'h140;
    uv = 1'b1; upc = 32'h140; ub = 1'b1; ut = 1'b1; utgt = 32'h400; um = 1'b0;
    #1 chk("same.before", tgt, 32'h200);
    @(posedge clock); #1;
    uv = 1'b0;
    chk("same.after", tgt, 32'h400);

    // five mispredicts (not-taken misses, table untouched)
    for (int i = 0; i < 5; i++) upd(32'h80, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("mp.count", s_mp, 32'd5);
    chk("mp.lookups", s_lk, 32'd16);

    // asynchronous reset mid-cycle with an update pending
    @(negedge clock);
    uv = 1'b1; upc = 32'h140; ub = 1'b1; ut = 1'b1; utgt = 32'h500;
    #2 reset = 1'b0;
    #1;
    look(32'h140, "arst", 1'b0, 1'b0, 32'h144);
    chk("arst.lookups", s_lk, 32'h0);
    chk("arst.mispred", s_mp, 32'h0);
    chk("arst.ghr", 32'(ghr), 32'h0);
    @(posedge clock); #1;
    uv = 1'b0;
    chk("arst.noupd", 32'(hit), 32'h0);
    chk("arst.noupd.lk", s_lk, 32'h0);
    @(negedge clock); reset = 1'b1;

    // gshare: two taken branches -> GHR 11
    gupd(32'h40, 2'b00, 1'b1, 1'b1, 32'h100);
    gupd(32'h40, 2'b01, 1'b1, 1'b1, 32'h104);
    chk("gs.ghr", 32'(g_ghr), 32'h3);
    // jump trained at pc 0 with history 11 lands at idx 3; GHR unchanged
    gupd(32'h0, 2'b11, 1'b0, 1'b1, 32'h500);
    chk("gs.ghr.jump", 32'(g_ghr), 32'h3);
    g_lu_pc = 32'h0; #1;
    chk("gs.pc0.hit", 32'(g_hit), 32'h1);
    chk("gs.pc0.target", g_tgt, 32'h500);
    chk("gs.pc0.ghr", 32'(g_ghr), 32'h3);
    // pc 0xC (pc_idx 3) now maps to idx 0, which is empty
    g_lu_pc = 32'hC; #1;
    chk("gs.pcC.hit", 32'(g_hit), 32'h0);
    chk("gs.pcC.target", g_tgt, 32'h10);
    chk("gs.lookups", g_s_lk, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised branch predictor for the Minisys-1A pipeline, combining a branch history table of saturating counters with a tagged branch target buffer. It sits beside the IF stage and is looked up combinationally with the fetch PC. It is trained one cycle-edge later from the ID-stage branch resolution, which remains responsible for flush and redirect. This replaces the fixed "predict taken" policy with per-PC history and an optional global-history (gshare) indexing mode.

## Interface
Parameters:
- `ENTRIES`, 64: number of table entries; power of two, 4..1024.
- `INDEX_W`, $clog2(ENTRIES): index width (derived; do not override).
- `TAG_W`, 8: stored tag bits; 1..(30-INDEX_W).
- `CNT_W`, 2: saturating counter width, 1..4.
- `GHR_W`, 6: global history length, 1..INDEX_W.
- `MODE`, 0: 0 = bimodal (PC index), 1 = gshare (PC index XOR history).

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `lu_pc`  in  32  fetch PC to predict.
- `pred_hit`  out  1  valid entry with matching tag.
- `pred_taken`  out  1  predicted taken.
- `pred_target`  out  32  predicted next PC.
- `pred_ghr`  out  GHR_W  history used for this lookup; carried down the pipe.
- `upd_valid`  in  1  resolution strobe from ID, one cycle per resolved instruction.
- `upd_pc`  in  32  PC of the resolved instruction.
- `upd_ghr`  in  GHR_W  `pred_ghr` captured at that instruction's lookup.
- `upd_is_branch`  in  1  1 = conditional branch, 0 = unconditional jump (J/JAL/JR/JALR).
- `upd_taken`  in  1  actual outcome.
- `upd_target`  in  32  actual taken target.
- `upd_mispredict`  in  1  ID detected a wrong prediction.
- `stat_lookups`  out  32  resolved updates counted.
- `stat_mispredicts`  out  32  mispredicts counted.

## Operation
Indexing and tags:
- `pc_idx = pc[INDEX_W+1:2]`.
- In gshare mode: `idx = pc_idx ^ {0, ghr}`. The lookup uses the live GHR; the update uses `upd_ghr`.
- `tag = pc[TAG_W+INDEX_W+1:INDEX_W+2]`.

Entry state:
- Each entry holds `{valid, tag, target[31:2], cnt}`.
- Targets are word aligned; bits [1:0] are reconstructed as 00.

Lookup (combinational):
- `pred_hit = valid && tag match`.
- `pred_taken = pred_hit && cnt[CNT_W-1]`.
- `pred_target = pred_taken ? stored target : lu_pc + 4`, modulo 2^32.
- `pred_ghr` equals the current GHR.

Update, on the clock edge with `upd_valid = 1`:
- **Conditional branch, hit:** cnt saturates up if taken, down if not. If taken, target is rewritten with `upd_target`.
- **Conditional branch, miss, taken:** allocate the entry (overwrite valid/tag/target) with cnt = max.
- **Conditional branch, miss, not taken:** no allocation; the table is unchanged.
- **Jump:** always allocate or overwrite with cnt = max and target = `upd_target`.
- **GHR:** `ghr <= {ghr[GHR_W-2:0], upd_taken}` only when `upd_is_branch`. Jumps leave the GHR unchanged.
- **Statistics:**
  - `stat_lookups` increments on every `upd_valid`.
  - `stat_mispredicts` increments on `upd_valid && upd_mispredict`.
  - Both saturate at 0xFFFF_FFFF.
- `upd_*` inputs are ignored when `upd_valid = 0`.

## Timing
- Lookup has zero latency: outputs settle in the same cycle as `lu_pc`.
- Updates are visible to lookups from the cycle after the training edge.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update value; there is no bypass.
- Reset (asynchronous assert, any cycle, including mid-update):
  - All valid bits are cleared, every cnt is set to weakly taken (`1 << (CNT_W-1)`), GHR is cleared, and both statistics are cleared.
  - Immediately after reset: `pred_hit = 0`, `pred_taken = 0`, `pred_target = lu_pc + 4`, `pred_ghr = 0`, statistics = 0.
- Reset release is synchronous to `clock`. No update is taken on the edge where reset is low.
- Aliasing: different PCs sharing an index evict each other by tag. A tag mismatch always reads as a miss, never as not-taken.
- Wrap-around:
  - `lu_pc = 0xFFFF_FFFC` on a miss gives `pred_target = 0x0000_0000`.
  - The cnt never wraps.

## Test plan
- **Reset then lookup:** reset low, then release; `lu_pc = 0x0000_0040` → `pred_hit = 0`, `pred_taken = 0`, `pred_target = 0x0000_0044`, statistics = 0.
- **Allocate and hit:** update pc 0x40, branch, taken, target 0x100 → next cycle lookup 0x40 gives `hit = 1`, `taken = 1`, `target = 0x100`, `stat_lookups = 1`.
- **Counter saturation (CNT_W = 2):** after the previous step, apply three not-taken updates to 0x40 → `taken = 0` after the second. A fourth not-taken update keeps cnt = 00; one taken update gives 01, still not-taken.
- **Tag alias:** ENTRIES = 64; pc 0x40 is allocated, then pc 0x140 (same index, different tag) is taken to 0x200 → lookup 0x40 gives `hit = 0`, target 0x44; lookup 0x140 gives target 0x200.
- **Gshare (MODE = 1, GHR_W = 2):** two taken branch updates leave GHR = 11. A lookup of pc 0x0 then uses idx 3 and `pred_ghr = 11`. A jump update leaves GHR = 11.
- **Statistics and simultaneous events:**
  - Same-cycle lookup and update on 0x40: the lookup shows the old value.
  - Five updates with `upd_mispredict = 1` give `stat_mispredicts = 5`.
  - Asserting reset mid-stream clears everything within the same cycle, asynchronously.
